// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing defaults, monitor state encoding and window helper
package vga_timing_pkg;
  localparam int H_TOTAL_DEF = 800;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_SYNC_TO_ACTIVE_DEF = 144;
  localparam int V_TOTAL_DEF = 525;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_SYNC_TO_ACTIVE_DEF = 35;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  function automatic logic in_win(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: two-stage synchroniser for an active-low sync with falling-edge strobe
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);
  logic s1, s2;
  // idle level of an active-low sync is high, so both stages reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end
  // strobe while the second stage is about to take the new low level
  assign fall = s2 & ~s1;
endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers VGA timing, coordinates, lock status and per-frame pixel sum
module vga_rx_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_SYNC_TO_ACTIVE = H_SYNC_TO_ACTIVE_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_SYNC_TO_ACTIVE = V_SYNC_TO_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  pixel_in,
  output logic        rx_de,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [2:0]  rx_pixel,
  output logic        locked,
  output logic        timing_err,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas,
  output logic        frame_done,
  output logic [21:0] frame_sum
);
  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [9:0] HS = 10'(H_SYNC_TO_ACTIVE);
  localparam logic [9:0] HE = 10'(H_SYNC_TO_ACTIVE + H_ACTIVE);
  localparam logic [9:0] VS = 10'(V_SYNC_TO_ACTIVE);
  localparam logic [9:0] VE = 10'(V_SYNC_TO_ACTIVE + V_ACTIVE);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  logic h_fall, v_fall;
  logic [2:0] p1, p2;
  logic [9:0] hpos, vpos, v_len;
  logic [1:0] state, nxt;
  logic [3:0] good_cnt;
  logic [21:0] acc;
  logic v_pend, line_bad, fr_valid;
  logic sat, h_bad, v_bad, frame_ok, err_d;
  vga_sync_edge u_hs (.clk(clk), .rst(rst), .d(hsync_in), .fall(h_fall));
  vga_sync_edge u_vs (.clk(clk), .rst(rst), .d(vsync_in), .fall(v_fall));
  assign sat = hpos == 10'd1023;
  assign v_len = vpos + 10'd1;
  assign h_bad = h_fall && (hpos + 10'd1 != HT);
  assign v_bad = v_len != VT;
  assign frame_ok = !(line_bad || h_bad) && !v_bad;
  assign locked = state == ST_LOCKED;
  assign rx_de = state != ST_SEARCH && in_win(hpos, HS, HE) && in_win(vpos, VS, VE);
  assign rx_x = rx_de ? hpos - HS : 10'd0;
  assign rx_y = rx_de ? vpos - VS : 10'd0;
  assign rx_pixel = p2;
  // lock FSM: TRACK only judges a frame at its end, LOCKED drops out on the first fault
  always_comb begin
    err_d = locked && (h_bad || (v_fall && v_bad) || sat);
    nxt = err_d ? ST_SEARCH
        : state == ST_SEARCH ? (v_fall ? ST_TRACK : ST_SEARCH)
        : state == ST_TRACK ? (sat || (v_fall && !frame_ok) ? ST_SEARCH
                              : v_fall && good_cnt + 4'd1 == LF ? ST_LOCKED : ST_TRACK)
        : state == ST_LOCKED ? ST_LOCKED : ST_SEARCH;
  end
  // pixel pipeline and line/frame position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= 3'd0;
      p2 <= 3'd0;
      hpos <= 10'd0;
      vpos <= 10'd0;
      v_pend <= 1'b0;
      h_meas <= 10'd0;
      v_meas <= 10'd0;
    end else begin
      p1 <= pixel_in;
      p2 <= p1;
      hpos <= h_fall ? 10'd0 : sat ? hpos : hpos + 10'd1;
      v_pend <= !h_fall && (v_fall || v_pend);
      if (h_fall) h_meas <= hpos + 10'd1;
      if (h_fall) vpos <= (v_fall || v_pend) ? 10'd0 : vpos + 10'd1;
      if (v_fall) v_meas <= v_len;
    end
  end
  // lock state, good-frame count and the registered error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEARCH;
      good_cnt <= 4'd0;
      line_bad <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state <= nxt;
      timing_err <= err_d;
      line_bad <= !v_fall && (line_bad || h_bad);
      if (v_fall) good_cnt <= state == ST_TRACK && frame_ok ? good_cnt + 4'd1 : 4'd0;
    end
  end
  // active-area pixel accumulation, published only for frames that began while tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 22'd0;
      fr_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_sum <= 22'd0;
    end else begin
      acc <= v_fall ? 22'd0 : acc + (rx_de ? {19'd0, rx_pixel} : 22'd0);
      frame_done <= v_fall && fr_valid;
      if (v_fall) fr_valid <= nxt != ST_SEARCH;
      if (v_fall && fr_valid) frame_sum <= acc;
    end
  end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: scoreboard bench driving a scaled-down VGA raster into the monitor
module tb_vga_rx_monitor;
  logic clk = 1'b0;
  logic rst, hsync_in, vsync_in;
  logic [2:0] pixel_in;
  logic rx_de, locked, timing_err, frame_done;
  logic [9:0] rx_x, rx_y, h_meas, v_meas;
  logic [2:0] rx_pixel;
  logic [21:0] frame_sum;
  int n_vec = 0, n_err = 0, done_cnt = 0, err_cyc = 0;
  logic [22:0] px_q[$];
  int sum_q[$];
  vga_rx_monitor #(
    .H_TOTAL(40), .H_ACTIVE(16), .H_SYNC_TO_ACTIVE(12),
    .V_TOTAL(20), .V_ACTIVE(8), .V_SYNC_TO_ACTIVE(6), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .rx_de(rx_de), .rx_x(rx_x), .rx_y(rx_y), .rx_pixel(rx_pixel), .locked(locked),
    .timing_err(timing_err), .h_meas(h_meas), .v_meas(v_meas),
    .frame_done(frame_done), .frame_sum(frame_sum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // output side of the scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (timing_err) err_cyc++;
    if (rx_de) begin
      if (px_q.size() == 0) chk("de_unexpected", 32'(rx_de), 32'd0);
      else chk("pixel_xy", 32'({rx_x, rx_y, rx_pixel}), 32'(px_q.pop_front()));
    end
    if (frame_done) begin
      done_cnt++;
      if (sum_q.size() == 0) chk("done_unexpected", 32'(frame_done), 32'd0);
      else chk("frame_sum", 32'(frame_sum), 32'(sum_q.pop_front()));
    end
  end
  // one frame in sync-relative time: line 0 starts with both syncs falling,
  // hsync low 4 clks, active x 12..27 on lines 6..13, vsync low on lines 0..1
  task automatic drive_frame(input int nl, input int short_ln, input int hold_ln, input int rst_ln,
                             input int mode, input bit trk, input bit exp_done);
    int sum, len;
    bit t, act;
    logic [2:0] p;
    logic [9:0] x, y;
    sum = 0;
    t = trk;
    for (int l = 0; l < nl; l++) begin
      if (l == hold_ln) begin
        chk("locked_before_hold", 32'(locked), 32'd1);
        for (int c = 0; c < 1100; c++) begin
          tick();
          hsync_in = 1'b1;
          vsync_in = 1'b1;
          pixel_in = 3'd0;
        end
        chk("hold_de", 32'(rx_de), 32'd0);
        chk("hold_locked", 32'(locked), 32'd0);
        break;
      end
      len = (l == short_ln) ? 39 : 40;
      for (int c = 0; c < len; c++) begin
        tick();
        x = 10'(c - 12);
        y = 10'(l - 6);
        act = c >= 12 && c < 28 && l >= 6 && l < 14;
        p = !act ? 3'($urandom_range(7, 0)) : mode == 0 ? 3'd7 : mode == 1 ? x[2:0] : 3'($urandom_range(7, 0));
        if (l == rst_ln && c == 20) begin
          chk("locked_before_rst", 32'(locked), 32'd1);
          t = 1'b0;
        end
        if (l == rst_ln && c == 21) begin
          chk("rst_de", 32'(rx_de), 32'd0);
          chk("rst_locked", 32'(locked), 32'd0);
          chk("rst_h_meas", 32'(h_meas), 32'd0);
          chk("rst_v_meas", 32'(v_meas), 32'd0);
          chk("rst_frame_sum", 32'(frame_sum), 32'd0);
          chk("rst_rx_pixel", 32'(rx_pixel), 32'd0);
          px_q.delete();
        end
        rst = l == rst_ln && c == 20;
        hsync_in = c >= 4;
        vsync_in = l >= 2;
        pixel_in = p;
        if (act && t) begin
          px_q.push_back({x, y, p});
          sum += int'(p);
        end
      end
    end
    if (exp_done) sum_q.push_back(sum);
  endtask
  initial begin
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    pixel_in = 3'd5;
    repeat (3) tick();
    chk("reset_rx_de", 32'(rx_de), 32'd0);
    chk("reset_rx_x", 32'(rx_x), 32'd0);
    chk("reset_rx_y", 32'(rx_y), 32'd0);
    chk("reset_rx_pixel", 32'(rx_pixel), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_timing_err", 32'(timing_err), 32'd0);
    chk("reset_h_meas", 32'(h_meas), 32'd0);
    chk("reset_v_meas", 32'(v_meas), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_frame_sum", 32'(frame_sum), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    drive_frame(20, -1, -1, -1, 0, 1, 1);
    chk("locked_after_1_edge", 32'(locked), 32'd0);
    drive_frame(20, -1, -1, -1, 0, 1, 1);
    chk("locked_after_2_edges", 32'(locked), 32'd0);
    drive_frame(20, -1, -1, -1, 1, 1, 1);
    chk("locked_after_3_edges", 32'(locked), 32'd1);
    chk("h_meas_nominal", 32'(h_meas), 32'd40);
    chk("v_meas_nominal", 32'(v_meas), 32'd20);
    drive_frame(20, -1, -1, -1, 2, 1, 1);
    drive_frame(20, 16, -1, -1, 2, 1, 1);
    chk("short_line_unlock", 32'(locked), 32'd0);
    chk("short_line_err_cycles", 32'(err_cyc), 32'd1);
    drive_frame(20, -1, -1, -1, 0, 1, 1);
    chk("relock_wait_1", 32'(locked), 32'd0);
    drive_frame(20, -1, -1, -1, 1, 1, 1);
    chk("relock_wait_2", 32'(locked), 32'd0);
    drive_frame(20, -1, 16, -1, 0, 1, 1);
    chk("hold_err_cycles", 32'(err_cyc), 32'd2);
    drive_frame(20, -1, -1, -1, 2, 1, 1);
    chk("v_meas_after_hold", 32'(v_meas), 32'd16);
    drive_frame(19, -1, -1, -1, 0, 1, 1);
    drive_frame(20, -1, -1, -1, 2, 0, 0);
    chk("short_frame_v_meas", 32'(v_meas), 32'd19);
    chk("short_frame_no_lock", 32'(locked), 32'd0);
    chk("short_frame_no_err", 32'(err_cyc), 32'd2);
    drive_frame(20, -1, -1, -1, 1, 1, 1);
    drive_frame(20, -1, -1, -1, 2, 1, 1);
    drive_frame(20, -1, -1, 10, 0, 1, 0);
    drive_frame(20, -1, -1, -1, 2, 1, 1);
    drive_frame(3, -1, -1, -1, 0, 1, 0);
    repeat (10) tick();
    chk("frame_done_count", 32'(done_cnt), 32'd13);
    chk("sums_outstanding", 32'(sum_q.size()), 32'd0);
    chk("pixels_outstanding", 32'(px_q.size()), 32'd0);
    chk("total_err_cycles", 32'(err_cyc), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
